// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks read addresses and streams each word out over valid/ready.
// Optional REGDUMP_CSUM_EN appends a trailing XOR-checksum beat after the last register.
module regfile_dump_reader #(
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int SKIP_X0 = 0
) (
    input  logic          clk,
    input  logic          reg_reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          out_csum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        CSUM  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [AW-1:0] FIRST = AW'(SKIP_X0);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
`ifdef REGDUMP_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] idx;
    logic          hs;
    logic          is_last;
    logic          arm;
    logic          load;
    logic          adv;
    logic          fin;
    logic          csum_load;
    logic [DW-1:0] csum_word;

    assign hs      = out_valid && out_ready;
    assign is_last = (idx == LAST);

    // State register
    always_ff @(posedge clk or negedge reg_reset) begin
        if (!reg_reset) state <= IDLE;
        else            state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: next_state = SEND;
            SEND: begin
                if (hs) begin
                    if (!is_last) next_state = FETCH;
`ifdef REGDUMP_CSUM_EN
                    else          next_state = CSUM;
`else
                    else          next_state = FIN;
`endif
                end
            end
`ifdef REGDUMP_CSUM_EN
            CSUM:  if (hs) next_state = FIN;
`endif
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        arm       = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        fin       = 1'b0;
        csum_load = 1'b0;
        case (state)
            IDLE:  arm = start;
            FETCH: load = 1'b1;
            SEND:  adv = hs && !is_last;
`ifdef REGDUMP_CSUM_EN
            CSUM:  csum_load = !out_valid;
`endif
            FIN:   fin = 1'b1;
            default: ;
        endcase
    end

    // Address walk, status flags and the output beat register
    always_ff @(posedge clk or negedge reg_reset) begin
        if (!reg_reset) begin
            idx       <= FIRST;
            rd_addr   <= FIRST;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= fin;
            if (arm) begin
                idx     <= FIRST;
                rd_addr <= FIRST;
                busy    <= 1'b1;
            end
            if (adv) begin
                idx     <= idx + 1'b1;
                rd_addr <= idx + 1'b1;
            end
            if (fin) begin
                busy    <= 1'b0;
                idx     <= FIRST;
                rd_addr <= FIRST;
            end
            if (hs) out_valid <= 1'b0;
            if (load) begin
                out_data  <= rd_data;
                out_index <= idx;
                out_last  <= is_last && !CSUM_EN;
                out_valid <= 1'b1;
            end
            if (csum_load) begin
                out_data  <= csum_word;
                out_index <= '0;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end
        end
    end

`ifdef REGDUMP_CSUM_EN
    logic [DW-1:0] acc;

    assign csum_word = acc;

    // Running XOR of streamed words and the checksum-beat flag
    always_ff @(posedge clk or negedge reg_reset) begin
        if (!reg_reset) begin
            acc      <= '0;
            out_csum <= 1'b0;
        end else begin
            if (arm)       acc <= '0;
            if (load)      acc <= acc ^ rd_data;
            if (load)      out_csum <= 1'b0;
            if (csum_load) out_csum <= 1'b1;
        end
    end
`else
    assign csum_word = '0;
    assign out_csum  = 1'b0;
`endif

endmodule
